// File: rtl/counter_pkg.sv
// Shared constants and types for the free-running counter and its helpers.
package counter_pkg;

   localparam int unsigned COUNTER_W_DEFAULT  = 8;
   localparam int unsigned WRAP_CNT_W_DEFAULT = 8;

   typedef logic [COUNTER_W_DEFAULT-1:0] count_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_i, holds once it reaches all-ones.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         full;

   assign full = &cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !full) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/counter_8bit.sv
// Free-running wrapping up-counter with terminal-count decode, a one-cycle wrap pulse
// and a saturating count of wraps since reset.
module counter_8bit
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH      = COUNTER_W_DEFAULT,
   parameter int unsigned WRAP_CNT_W = WRAP_CNT_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [WIDTH-1:0]      count,
   output logic                  tc,
   output logic                  wrap,
   output logic [WRAP_CNT_W-1:0] wrap_cnt
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;

   assign tc = &count_q;

   always_comb begin
      count_d = count_q + WIDTH'(1);
      // Max always rolls to zero on the next edge, so the pulse is just tc delayed.
      wrap_d  = tc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   sat_counter #(
      .W (WRAP_CNT_W)
   ) u_wrap_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (tc),
      .cnt_o (wrap_cnt)
   );

   assign count = count_q;
   assign wrap  = wrap_q;

`ifndef SYNTHESIS
   wrap_single_cycle_a : assert property (@(posedge clk) disable iff (!rst_n) wrap |=> !wrap);
`endif

endmodule

// File: tb/tb_counter_8bit.sv
// Scoreboard bench for counter_8bit: stimulus queues hand-computed expectations, a monitor
// process pops and compares them against the live outputs.
module tb_counter_8bit;
   import counter_pkg::*;

   logic         clk;
   logic         rst_n;
   count_t       count;
   logic         tc;
   logic         wrap;
   logic [7:0]   wrap_cnt;

   counter_8bit #(
      .WIDTH      (8),
      .WRAP_CNT_W (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .count    (count),
      .tc       (tc),
      .wrap     (wrap),
      .wrap_cnt (wrap_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      count_t     cnt;
      logic       tc;
      logic       wrap;
      logic [7:0] wc;
      bit         use_p;
      int         pulses;
   } exp_t;

   exp_t exp_q[$];
   int   n_push = 0;
   int   n_pop  = 0;
   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;

   // Wrap pulses seen since the last reset, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) pulses <= 0;
      else if (wrap === 1'b1) pulses <= pulses + 1;
   end

   task automatic expect_out(input string name, input count_t c, input logic t,
                             input logic w, input logic [7:0] wc);
      exp_t e;
      e.name = name; e.cnt = c; e.tc = t; e.wrap = w; e.wc = wc;
      e.use_p = 1'b0; e.pulses = 0;
      exp_q.push_back(e);
      n_push++;
   endtask

   task automatic expect_pulses(input string name, input int n);
      exp_t e;
      e.name = name; e.cnt = '0; e.tc = 1'b0; e.wrap = 1'b0; e.wc = '0;
      e.use_p = 1'b1; e.pulses = n;
      exp_q.push_back(e);
      n_push++;
   endtask

   // Monitor: compares whenever an expectation is presented.
   initial begin
      exp_t e;
      forever begin
         wait (n_push != n_pop);
         e = exp_q.pop_front();
         n_pop++;
         checks++;
         if (e.use_p) begin
            if (pulses != e.pulses) begin
               errors++;
               $display("FAIL %s: pulses got %0d want %0d", e.name, pulses, e.pulses);
            end
         end else if (count !== e.cnt || tc !== e.tc || wrap !== e.wrap || wrap_cnt !== e.wc) begin
            errors++;
            $display("FAIL %s: got count=%0d tc=%b wrap=%b wrap_cnt=%0d want count=%0d tc=%b wrap=%b wrap_cnt=%0d",
                     e.name, count, tc, wrap, wrap_cnt, e.cnt, e.tc, e.wrap, e.wc);
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Assert reset mid-cycle, then release between edges (after a negedge).
   task automatic do_reset();
      #2 rst_n = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      #1 expect_out("rst_initial", 8'd0, 1'b0, 1'b0, 8'd0);
      repeat (2) @(posedge clk);
      #2 expect_out("rst_held", 8'd0, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      expect_out("rst_released", 8'd0, 1'b0, 1'b0, 8'd0);
      run(1);
      expect_out("first_edge", 8'd1, 1'b0, 1'b0, 8'd0);
      run(9);
      expect_out("ten_edges", 8'd10, 1'b0, 1'b0, 8'd0);

      do_reset();
      run(255);
      expect_out("at_max", 8'd255, 1'b1, 1'b0, 8'd0);
      run(1);
      expect_out("wrap_edge", 8'd0, 1'b0, 1'b1, 8'd1);
      run(1);
      expect_out("after_wrap", 8'd1, 1'b0, 1'b0, 8'd1);

      do_reset();
      run(768);
      expect_out("three_wraps", 8'd0, 1'b0, 1'b1, 8'd3);
      @(negedge clk);
      #1 expect_pulses("three_pulses", 3);

      do_reset();
      run(100);
      expect_out("at_100", 8'd100, 1'b0, 1'b0, 8'd0);
      #2 rst_n = 1'b0;
      #1 expect_out("async_rst_mid", 8'd0, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      run(1);
      expect_out("async_rst_release", 8'd1, 1'b0, 1'b0, 8'd0);

      do_reset();
      run(256 * 256 + 256);
      expect_out("saturated", 8'd0, 1'b0, 1'b1, 8'd255);
      @(negedge clk);
      #1 expect_pulses("sat_pulses", 257);

      do_reset();
      run(255);
      expect_out("max_before_rst", 8'd255, 1'b1, 1'b0, 8'd0);
      #2 rst_n = 1'b0;
      #1 expect_out("rst_at_max", 8'd0, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      run(1);
      expect_out("no_wrap_after_rst", 8'd1, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      #1 expect_pulses("no_pulse_after_rst", 0);

      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_8bit.md
Name: counter_8bit

Overview:
- Free-running synchronous up-counter, 8 bits wide by default, clocked by a single clock.
- Increments by one on every rising clock edge while out of reset and wraps modulo 2^WIDTH.
- Provides terminal-count and wrap status so surrounding logic can build timers and dividers without re-decoding the count.
- Leaf block with no handshake; instantiated directly under timing/control logic.

Parameters:
- WIDTH, 8, counter width in bits; legal range 2..32.
- WRAP_CNT_W, 8, width of the saturating wrap-event counter.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset; assertion is immediate, deassertion is sampled on clk.
- count  output  WIDTH  current counter value, registered.
- tc  output  1  terminal count; combinational, high when count == 2^WIDTH-1.
- wrap  output  1  registered one-cycle pulse, high in the cycle after count goes from max to 0, i.e. while count == 0 following a wrap.
- wrap_cnt  output  WRAP_CNT_W  number of wraps since reset, registered, saturating at all-ones.

Behaviour:
- Only count, wrap and wrap_cnt are registered. All use clk rising edge and the same async reset. tc is pure decode.
- Reset (rst_n == 0, at any time, mid-count included) forces the following immediately, without waiting for clk:
  - count = 0
  - wrap = 0
  - wrap_cnt = 0
  - tc = 0 (follows count)
- Reset held low: all outputs stay at their reset values regardless of clk.
- First rising edge with rst_n == 1 is the first increment: count goes 0 -> 1. Latency from reset release to count == 1 is one clock edge.
- Each subsequent edge: count_next = count + 1, truncated to WIDTH bits, with no carry out.
- Wrap boundary: at count == 2^WIDTH-1 (255 for WIDTH = 8):
  - tc = 1 during that cycle.
  - Next edge: count = 0, wrap = 1, wrap_cnt increments.
  - Following edge: count = 1, wrap = 0.
- wrap is high for exactly one cycle per wrap. It can never be high in two consecutive cycles for WIDTH >= 2.
- wrap_cnt saturates: once it reaches all-ones it holds, and further wraps still pulse wrap.
- There is no enable, load or direction control. The count is strictly monotonic modulo 2^WIDTH.
- Reset asserted in the same cycle as a wrap: reset wins and all outputs go to zero.
- No X on any output after the first reset assertion. Before the first reset the outputs are undefined and must not be checked.

Decomposition:
- Package counter_pkg:
  - COUNTER_W_DEFAULT = 8
  - WRAP_CNT_W_DEFAULT = 8
  - typedef count_t as logic [COUNTER_W_DEFAULT-1:0]
- The module's parameter defaults reference these package constants.
- One sub-module is natural: sat_counter (saturating incrementer with increment-enable), used for wrap_cnt.
- The main count register, tc decode and wrap pulse stay in the top module.

Test Plan:
- Hold rst_n = 0 over 2 clk edges, then release between edges -> count = 0 during reset; count = 1 after the first edge, 10 after 10 edges; tc = 0, wrap = 0, wrap_cnt = 0.
- Run 255 edges from reset -> count = 255 and tc = 1. Next edge -> count = 0, wrap = 1, wrap_cnt = 1. Next edge -> count = 1, wrap = 0, tc = 0.
- Run 256*3 edges from reset -> count = 0, wrap_cnt = 3, and exactly 3 wrap pulses observed.
- Assert rst_n asynchronously mid-cycle at count = 100 -> count = 0 before the next clk edge. Release -> count = 1 after one edge.
- Run 256*256 + 256 edges -> wrap_cnt = 255 (saturated), wrap still pulses on every wrap, count = 0.
- Assert rst_n in the cycle where count = 255 -> count = 0, wrap = 0 and wrap_cnt = 0, with no wrap pulse afterwards.
